// File: rtl/vliw_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : vliw_regfile
//  Brief    : Shared integer register file for the STARBUG VLIW core. Each
//             lane gets two combinational read ports and one write port.
//             Same-cycle writes to one register are resolved by bundle slot
//             order, and the winning write is bypassed to readers in that
//             cycle. Write collisions are reported one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module vliw_regfile #(
  parameter int XLEN        = 32,
  parameter bit E_SUPPORTED = 1'b0,
  parameter int NLANES      = 4,
  parameter int CNTW        = 16
) (
  input  logic                         clk,
  input  logic                         reset,          // asynchronous, active-low
  input  logic [NLANES-1:0][4:0]       a1,
  input  logic [NLANES-1:0][4:0]       a2,
  output logic [NLANES-1:0][XLEN-1:0]  rd1,
  output logic [NLANES-1:0][XLEN-1:0]  rd2,
  input  logic [NLANES-1:0]            we3,
  input  logic [NLANES-1:0][4:0]       a3,
  input  logic [NLANES-1:0][XLEN-1:0]  wd3,
  output logic                         WriteConflictW,
  output logic [NLANES-1:0]            ConflictLaneW,
  output logic [CNTW-1:0]              ConflictCount
);

  localparam int NREG = E_SUPPORTED ? 16 : 32;
  localparam int AW   = E_SUPPORTED ? 4 : 5;

  // x0 is not stored; it is constant zero.
  logic [XLEN-1:0]   regs [1:NREG-1];
  // Register contents as seen this cycle, including this cycle's winning writes.
  logic [XLEN-1:0]   view [NREG];
  logic [NLANES-1:0] valid;
  logic [NLANES-1:0] loser;

  // A lane write counts only outside reset, to a nonzero in-range register.
  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      valid[l] = reset && we3[l] && (a3[l] != 5'd0) && (!E_SUPPORTED || !a3[l][4]);
    end
  end

  // Build the write-first view: ascending lane order lets the latest slot win.
  always_comb begin
    view[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      view[r] = regs[r];
    end
    for (int l = 0; l < NLANES; l++) begin
      if (valid[l]) begin
        view[a3[l][AW-1:0]] = wd3[l];
      end
    end
    view[0] = '0;
  end

  // A lane loses when any later valid lane targets the same register.
  always_comb begin
    loser = '0;
    for (int l = 0; l < NLANES; l++) begin
      for (int j = l + 1; j < NLANES; j++) begin
        if (valid[l] && valid[j] && (a3[l] == a3[j])) begin
          loser[l] = 1'b1;
        end
      end
    end
  end

  // Architectural state commits the resolved view every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        regs[r] <= view[r];
      end
    end
  end

  // Read ports: out-of-range addresses in the 16-register configuration read zero.
  generate
    for (genvar l = 0; l < NLANES; l++) begin : g_rd
      assign rd1[l] = (!E_SUPPORTED || !a1[l][4]) ? view[a1[l][AW-1:0]] : '0;
      assign rd2[l] = (!E_SUPPORTED || !a2[l][4]) ? view[a2[l][AW-1:0]] : '0;
    end
  endgenerate

  // Collision report, one cycle late, with a saturating event counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WriteConflictW <= 1'b0;
      ConflictLaneW  <= '0;
      ConflictCount  <= '0;
    end else begin
      WriteConflictW <= |loser;
      ConflictLaneW  <= loser;
      if ((|loser) && (ConflictCount != {CNTW{1'b1}})) begin
        ConflictCount <= ConflictCount + CNTW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vliw_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vliw_regfile
//  Brief    : Self-checking bench for vliw_regfile (32-register and
//             16-register configurations) using an expectation queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vliw_regfile;

  localparam int NL = 4;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset;

  logic [NL-1:0][4:0]  a1, a2, a3;
  logic [NL-1:0]       we3;
  logic [NL-1:0][31:0] wd3, rd1, rd2;
  logic                conf;
  logic [NL-1:0]       lanes;
  logic [15:0]         cnt;

  logic [NL-1:0][4:0]  a1e, a2e, a3e;
  logic [NL-1:0]       we3e;
  logic [NL-1:0][31:0] wd3e, rd1e, rd2e;
  logic                confe;
  logic [NL-1:0]       lanese;
  logic [15:0]         cnte;

  exp_t        sb[$];
  logic [31:0] obs[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  vliw_regfile #(.XLEN(32), .E_SUPPORTED(1'b0), .NLANES(NL), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .we3(we3), .a3(a3), .wd3(wd3),
    .WriteConflictW(conf), .ConflictLaneW(lanes), .ConflictCount(cnt)
  );

  vliw_regfile #(.XLEN(32), .E_SUPPORTED(1'b1), .NLANES(NL), .CNTW(16)) dut_e (
    .clk(clk), .reset(reset), .a1(a1e), .a2(a2e), .rd1(rd1e), .rd2(rd2e),
    .we3(we3e), .a3(a3e), .wd3(wd3e),
    .WriteConflictW(confe), .ConflictLaneW(lanese), .ConflictCount(cnte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    we3 = '0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
    we3e = '0; a1e = '0; a2e = '0; a3e = '0; wd3e = '0;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] o;
    sb.push_back('{"rst_conf", 32'h0});  obs.push_back(32'(conf));
    sb.push_back('{"rst_lanes", 32'h0}); obs.push_back(32'(lanes));
    sb.push_back('{"rst_count", 32'h0}); obs.push_back(32'(cnt));
    // store something so the mid-run reset has state to clear
    @(negedge clk); idle(); we3[0] = 1'b1; a3[0] = 5'd3; wd3[0] = 32'h33;
    @(posedge clk); #1 idle(); a1[0] = 5'd3; #1;
    sb.push_back('{"pre_rst_x3", 32'h33}); obs.push_back(rd1[0]);
    // reset low with writes pending on all lanes
    @(negedge clk); reset = 1'b0; we3 = 4'b1111;
    for (int l = 0; l < NL; l++) begin
      a3[l] = 5'(9 + l); wd3[l] = 32'hA0 + l; a1[l] = 5'(9 + l); a2[l] = 5'd3;
    end
    #1;
    for (int l = 0; l < NL; l++) begin
      sb.push_back('{$sformatf("inrst_rd1_%0d", l), 32'h0}); obs.push_back(rd1[l]);
      sb.push_back('{$sformatf("inrst_rd2_%0d", l), 32'h0}); obs.push_back(rd2[l]);
    end
    sb.push_back('{"inrst_count", 32'h0}); obs.push_back(32'(cnt));
    @(posedge clk);
    @(negedge clk); we3 = '0; reset = 1'b1;
    @(posedge clk); #1;
    for (int l = 0; l < NL; l++) begin
      sb.push_back('{$sformatf("postrst_x%0d", 9 + l), 32'h0}); obs.push_back(rd1[l]);
    end
    sb.push_back('{"postrst_x3", 32'h0}); obs.push_back(rd2[0]);
    sb.push_back('{"postrst_conf", 32'h0}); obs.push_back(32'(conf));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [31:0] o;
    @(negedge clk); idle();
    we3[0] = 1'b1; a3[0] = 5'd5; wd3[0] = 32'h11; a1[2] = 5'd5; a2[3] = 5'd5;
    #1;
    sb.push_back('{"byp_rd1_2", 32'h11}); obs.push_back(rd1[2]);
    sb.push_back('{"byp_rd2_3", 32'h11}); obs.push_back(rd2[3]);
    @(posedge clk); #1 idle(); a1[1] = 5'd5; a2[0] = 5'd5; #1;
    sb.push_back('{"stored_rd1_1", 32'h11}); obs.push_back(rd1[1]);
    sb.push_back('{"stored_rd2_0", 32'h11}); obs.push_back(rd2[0]);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    exp_t e; logic [31:0] o;
    @(negedge clk); idle();
    we3 = 4'b1010; a3[1] = 5'd7; wd3[1] = 32'hA; a3[3] = 5'd7; wd3[3] = 32'hB; a1[0] = 5'd7;
    #1;
    sb.push_back('{"col_bypass_x7", 32'hB}); obs.push_back(rd1[0]);
    @(posedge clk); #1 idle(); a2[2] = 5'd7; #1;
    sb.push_back('{"col_x7", 32'hB});     obs.push_back(rd2[2]);
    sb.push_back('{"col_conf", 32'h1});   obs.push_back(32'(conf));
    sb.push_back('{"col_lanes", 32'h2});  obs.push_back(32'(lanes));
    sb.push_back('{"col_count", 32'h1});  obs.push_back(32'(cnt));
    @(posedge clk); #1;
    sb.push_back('{"col_idle_conf", 32'h0});  obs.push_back(32'(conf));
    sb.push_back('{"col_idle_lanes", 32'h0}); obs.push_back(32'(lanes));
    sb.push_back('{"col_idle_count", 32'h1}); obs.push_back(32'(cnt));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_multi_collision();
    exp_t e; logic [31:0] o;
    @(negedge clk); idle();
    we3 = 4'b1111;
    a3[0] = 5'd8; wd3[0] = 32'h80; a3[1] = 5'd8; wd3[1] = 32'h81;
    a3[2] = 5'd9; wd3[2] = 32'h90; a3[3] = 5'd9; wd3[3] = 32'h91;
    @(posedge clk); #1 idle(); a1[0] = 5'd8; a1[1] = 5'd9; #1;
    sb.push_back('{"multi_x8", 32'h81});    obs.push_back(rd1[0]);
    sb.push_back('{"multi_x9", 32'h91});    obs.push_back(rd1[1]);
    sb.push_back('{"multi_conf", 32'h1});   obs.push_back(32'(conf));
    sb.push_back('{"multi_lanes", 32'h5});  obs.push_back(32'(lanes));
    sb.push_back('{"multi_count", 32'h2});  obs.push_back(32'(cnt));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_x0();
    exp_t e; logic [31:0] o;
    @(negedge clk); idle();
    we3 = 4'b1111;
    for (int l = 0; l < NL; l++) begin
      a3[l] = 5'd0; wd3[l] = 32'hFFFF;
    end
    #1;
    sb.push_back('{"x0_bypass", 32'h0}); obs.push_back(rd1[0]);
    @(posedge clk); #1 idle(); #1;
    sb.push_back('{"x0_read", 32'h0});   obs.push_back(rd2[3]);
    sb.push_back('{"x0_conf", 32'h0});   obs.push_back(32'(conf));
    sb.push_back('{"x0_lanes", 32'h0});  obs.push_back(32'(lanes));
    sb.push_back('{"x0_count", 32'h2});  obs.push_back(32'(cnt));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_e_config();
    exp_t e; logic [31:0] o;
    @(negedge clk); idle();
    we3e[0] = 1'b1; a3e[0] = 5'd20; wd3e[0] = 32'hDEAD; a1e[1] = 5'd20; a2e[1] = 5'd4;
    #1;
    sb.push_back('{"e_byp_x20", 32'h0}); obs.push_back(rd1e[1]);
    sb.push_back('{"e_byp_x4", 32'h0});  obs.push_back(rd2e[1]);
    @(posedge clk); #1 idle(); a1e[0] = 5'd4; a1e[1] = 5'd20; #1;
    sb.push_back('{"e_x4", 32'h0});      obs.push_back(rd1e[0]);
    sb.push_back('{"e_x20", 32'h0});     obs.push_back(rd1e[1]);
    // legal write to x4 alongside an illegal write that would alias onto it
    @(negedge clk); idle();
    we3e = 4'b1100; a3e[2] = 5'd4; wd3e[2] = 32'h44; a3e[3] = 5'd20; wd3e[3] = 32'hBAD;
    @(posedge clk); #1 idle(); a2e[0] = 5'd4; #1;
    sb.push_back('{"e_x4_kept", 32'h44}); obs.push_back(rd2e[0]);
    sb.push_back('{"e_conf", 32'h0});     obs.push_back(32'(confe));
    sb.push_back('{"e_lanes", 32'h0});    obs.push_back(32'(lanese));
    sb.push_back('{"e_count", 32'h0});    obs.push_back(32'(cnte));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      else n_pass++;
    end
  endtask

  task automatic test_saturate();
    exp_t e; logic [31:0] o;
    @(negedge clk); idle();
    we3 = 4'b1100; a3[2] = 5'd10; wd3[2] = 32'h1; a3[3] = 5'd10; wd3[3] = 32'h2;
    repeat ((1 << 16) + 3) @(posedge clk);
    #1;
    sb.push_back('{"sat_count", 32'hFFFF}); obs.push_back(32'(cnt));
    sb.push_back('{"sat_conf", 32'h1});     obs.push_back(32'(conf));
    sb.push_back('{"sat_lanes", 32'h4});    obs.push_back(32'(lanes));
    idle();
    @(posedge clk); #1;
    sb.push_back('{"sat_hold_count", 32'hFFFF}); obs.push_back(32'(cnt));
    sb.push_back('{"sat_idle_conf", 32'h0});     obs.push_back(32'(conf));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, o, e.exp);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    test_reset();
    test_bypass();
    test_collision();
    test_multi_collision();
    test_x0();
    test_e_config();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
